// File: rtl/kgd_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : kgd_scanout
//  Description : KGD video scan-out engine. Generates raster timing, walks the
//                KGD VRAM through its 1-bit registered read port and emits a
//                serial monochrome pixel stream with the 400x286 bitmap scaled
//                2x2 and placed at (X0, Y0) in the active raster.
//  Ports       : clock       - system clock, also clocks the VRAM read port
//                reset       - asynchronous active-high reset
//                pix_ce      - pixel clock enable; everything advances on it
//                vid_en      - display enable; 0 blanks window pixels
//                vram_addr   - VRAM port-B bit address (registered)
//                vram_q      - VRAM port-B data, valid one clock after address
//                pix         - pixel value
//                de          - active-video flag
//                hsync/vsync - sync outputs with polarity applied
//                frame_start - one-clock pulse when raster (0,0) is output
//  Revision    : 1.0 - initial release
// ============================================================================
module kgd_scanout #(
    parameter int H_ACT  = 1024,
    parameter int H_FP   = 24,
    parameter int H_SYNC = 136,
    parameter int H_BP   = 160,
    parameter int V_ACT  = 768,
    parameter int V_FP   = 3,
    parameter int V_SYNC = 6,
    parameter int V_BP   = 29,
    parameter bit HS_POL = 1'b0,
    parameter bit VS_POL = 1'b0,
    parameter int PIX_W  = 400,
    parameter int PIX_H  = 286,
    parameter int X0     = 112,
    parameter int Y0     = 98
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        vid_en,
    output logic [16:0] vram_addr,
    input  logic        vram_q,
    output logic        pix,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int c_H_TOT = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int c_V_TOT = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int c_HW    = $clog2(c_H_TOT);
    localparam int c_VW    = $clog2(c_V_TOT);
    localparam int c_CW    = $clog2(PIX_W + 1);
    localparam int c_AW    = 17;

    localparam logic [c_HW-1:0] c_H_LAST = c_HW'(c_H_TOT - 1);
    localparam logic [c_HW-1:0] c_H_ACT  = c_HW'(H_ACT);
    localparam logic [c_HW-1:0] c_HS_BEG = c_HW'(H_ACT + H_FP);
    localparam logic [c_HW-1:0] c_HS_END = c_HW'(H_ACT + H_FP + H_SYNC);
    localparam logic [c_HW-1:0] c_X_BEG  = c_HW'(X0);
    localparam logic [c_HW-1:0] c_X_END  = c_HW'(X0 + 2 * PIX_W);
    localparam logic [c_HW-1:0] c_X_LAST = c_HW'(X0 + 2 * PIX_W - 1);

    localparam logic [c_VW-1:0] c_V_LAST = c_VW'(c_V_TOT - 1);
    localparam logic [c_VW-1:0] c_V_ACT  = c_VW'(V_ACT);
    localparam logic [c_VW-1:0] c_VS_BEG = c_VW'(V_ACT + V_FP);
    localparam logic [c_VW-1:0] c_VS_END = c_VW'(V_ACT + V_FP + V_SYNC);
    localparam logic [c_VW-1:0] c_Y_BEG  = c_VW'(Y0);
    localparam logic [c_VW-1:0] c_Y_END  = c_VW'(Y0 + 2 * PIX_H);

    localparam logic [c_AW-1:0] c_LINE_STEP = c_AW'(PIX_W);

    // Raster and address-walk state
    logic [c_HW-1:0] r_hcnt;
    logic [c_VW-1:0] r_vcnt;
    logic [c_CW-1:0] r_col;
    logic            r_xodd;
    logic            r_yodd;
    logic [c_AW-1:0] r_line_base;

    // Pipeline flags: stage A registered from the counters, stage B delayed
    logic r_act_a, r_hs_a, r_vs_a, r_win_a, r_first_a;
    logic r_act_b, r_hs_b, r_vs_b, r_win_b, r_first_b;

    // Read-data capture
    logic r_ce_d1;
    logic r_q_b;

    // Timing decode
    logic w_h_last, w_v_last;
    logic w_act, w_hs, w_vs, w_win, w_win_end, w_first;
    logic w_q;

    assign w_h_last  = (r_hcnt == c_H_LAST);
    assign w_v_last  = (r_vcnt == c_V_LAST);
    assign w_act     = (r_hcnt < c_H_ACT) && (r_vcnt < c_V_ACT);
    assign w_hs      = (r_hcnt >= c_HS_BEG) && (r_hcnt < c_HS_END);
    assign w_vs      = (r_vcnt >= c_VS_BEG) && (r_vcnt < c_VS_END);
    assign w_win     = (r_hcnt >= c_X_BEG) && (r_hcnt < c_X_END) &&
                       (r_vcnt >= c_Y_BEG) && (r_vcnt < c_Y_END);
    assign w_win_end = (r_hcnt == c_X_LAST);
    assign w_first   = (r_hcnt == '0) && (r_vcnt == '0);

    // ------------------------------------------------------------------------
    // Raster counters
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (pix_ce) begin
            if (w_h_last) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_last ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Address walk: column advances every second window pixel, line base
    // advances every second window line, giving the 2x2 scale without a
    // multiplier. vram_addr is the stage-A address register and holds its
    // last value outside the window.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_col       <= '0;
            r_xodd      <= 1'b0;
            r_yodd      <= 1'b0;
            r_line_base <= '0;
            vram_addr   <= '0;
        end else if (pix_ce) begin
            if (w_win) begin
                vram_addr <= r_line_base + c_AW'(r_col);
                r_xodd    <= ~r_xodd;
                if (r_xodd) begin
                    r_col <= r_col + 1'b1;
                end
                if (w_win_end) begin
                    r_yodd <= ~r_yodd;
                    if (r_yodd) begin
                        r_line_base <= r_line_base + c_LINE_STEP;
                    end
                end
            end
            if (w_h_last) begin
                r_col  <= '0;
                r_xodd <= 1'b0;
                if (w_v_last) begin
                    r_line_base <= '0;
                    r_yodd      <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Read-data capture. The RAM registers the address on the clock after a
    // strobe, so the word for the address issued at the previous strobe is
    // on vram_q during the clock that follows a strobe. It is latched there
    // so that slow pix_ce spacing cannot let the next address overwrite it;
    // when strobes are back to back the live vram_q is used directly.
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_ce_d1 <= 1'b0;
            r_q_b   <= 1'b0;
        end else begin
            r_ce_d1 <= pix_ce;
            if (r_ce_d1) begin
                r_q_b <= vram_q;
            end
        end
    end

    assign w_q = r_ce_d1 ? vram_q : r_q_b;

    // ------------------------------------------------------------------------
    // Flag pipeline and output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_act_a   <= 1'b0;
            r_hs_a    <= 1'b0;
            r_vs_a    <= 1'b0;
            r_win_a   <= 1'b0;
            r_first_a <= 1'b0;
            r_act_b   <= 1'b0;
            r_hs_b    <= 1'b0;
            r_vs_b    <= 1'b0;
            r_win_b   <= 1'b0;
            r_first_b <= 1'b0;
            pix       <= 1'b0;
            de        <= 1'b0;
            hsync     <= ~HS_POL;
            vsync     <= ~VS_POL;
        end else if (pix_ce) begin
            r_act_a   <= w_act;
            r_hs_a    <= w_hs;
            r_vs_a    <= w_vs;
            r_win_a   <= w_win;
            r_first_a <= w_first;
            r_act_b   <= r_act_a;
            r_hs_b    <= r_hs_a;
            r_vs_b    <= r_vs_a;
            r_win_b   <= r_win_a;
            r_first_b <= r_first_a;
            // window lies inside the active area, so pix is 0 whenever de is 0
            pix       <= r_win_b & vid_en & w_q;
            de        <= r_act_b;
            hsync     <= r_hs_b ? HS_POL : ~HS_POL;
            vsync     <= r_vs_b ? VS_POL : ~VS_POL;
        end
    end

    // Updated every clock so the pulse lasts one clock regardless of spacing
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce & r_first_b;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kgd_scanout.sv
`default_nettype none
// ============================================================================
//  Module      : tb_kgd_scanout
//  Description : Self-checking bench for kgd_scanout on a reduced raster.
//                A raster-position model predicts address and outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_kgd_scanout;

    localparam int H_ACT  = 40;
    localparam int H_FP   = 4;
    localparam int H_SYNC = 6;
    localparam int H_BP   = 6;
    localparam int V_ACT  = 30;
    localparam int V_FP   = 2;
    localparam int V_SYNC = 3;
    localparam int V_BP   = 3;
    localparam bit HS_POL = 1'b0;
    localparam bit VS_POL = 1'b1;
    localparam int PIX_W  = 12;
    localparam int PIX_H  = 10;
    localparam int X0     = 6;
    localparam int Y0     = 4;

    localparam int H_TOT     = H_ACT + H_FP + H_SYNC + H_BP;
    localparam int V_TOT     = V_ACT + V_FP + V_SYNC + V_BP;
    localparam int F_STROBES = H_TOT * V_TOT;
    localparam int N_BITS    = PIX_W * PIX_H;

    logic        clock  = 1'b0;
    logic        reset  = 1'b1;
    logic        pix_ce = 1'b0;
    logic        vid_en = 1'b1;
    logic        vram_q = 1'b0;
    logic [16:0] vram_addr;
    logic        pix, de, hsync, vsync, frame_start;

    kgd_scanout #(
        .H_ACT(H_ACT), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACT(V_ACT), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HS_POL(HS_POL), .VS_POL(VS_POL),
        .PIX_W(PIX_W), .PIX_H(PIX_H), .X0(X0), .Y0(Y0)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .vid_en      (vid_en),
        .vram_addr   (vram_addr),
        .vram_q      (vram_q),
        .pix         (pix),
        .de          (de),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    // Registered VRAM read port
    bit mem [0:N_BITS-1];
    always @(posedge clock) begin
        vram_q <= (int'(vram_addr) < N_BITS) ? mem[int'(vram_addr)] : 1'b0;
    end

    typedef struct {
        int h;
        int v;
        bit act;
        bit hs;
        bit vs;
        bit win;
        bit first;
        int addr;
    } item_t;

    localparam logic [4:0] RST_OUT = {1'b0, 1'b0, ~HS_POL, ~VS_POL, 1'b0};

    int         checks   = 0;
    int         failures = 0;
    int         s_cnt    = 0;
    int         last_addr = 0;
    item_t      pipe[$];
    logic [4:0] exp_out  = RST_OUT;
    int         st_de, st_hs, st_vs, st_fs;
    int         first8 [8] = '{0, 0, 1, 1, 2, 2, 3, 3};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Everything a raster position implies, from position index since reset
    function automatic item_t model(input int p);
        item_t it;
        it.h     = p % H_TOT;
        it.v     = (p / H_TOT) % V_TOT;
        it.act   = (it.h < H_ACT) && (it.v < V_ACT);
        it.hs    = (it.h >= H_ACT + H_FP) && (it.h < H_ACT + H_FP + H_SYNC);
        it.vs    = (it.v >= V_ACT + V_FP) && (it.v < V_ACT + V_FP + V_SYNC);
        it.win   = (it.h >= X0) && (it.h < X0 + 2 * PIX_W) &&
                   (it.v >= Y0) && (it.v < Y0 + 2 * PIX_H);
        it.first = (p % F_STROBES) == 0;
        it.addr  = it.win ? ((it.v - Y0) / 2) * PIX_W + (it.h - X0) / 2 : 0;
        return it;
    endfunction

    task automatic tick(input bit ce, input bit en);
        item_t it;
        item_t c;
        pix_ce = ce;
        vid_en = en;
        @(posedge clock);
        exp_out[0] = 1'b0;
        if (ce) begin
            it = model(s_cnt);
            s_cnt++;
            if (it.win) last_addr = it.addr;
            pipe.push_back(it);
            if (pipe.size() == 3) begin
                c = pipe.pop_front();
                exp_out = {c.win & en & mem[c.addr], c.act,
                           c.hs ? HS_POL : ~HS_POL, c.vs ? VS_POL : ~VS_POL, c.first};
            end
        end
        #1;
        chk("vram_addr", 32'(vram_addr), last_addr);
        chk("outputs", {27'd0, pix, de, hsync, vsync, frame_start}, {27'd0, exp_out});
        if (ce) begin
            if (it.v == Y0 && it.h >= X0 && it.h < X0 + 8)
                chk("addr_first_line", 32'(vram_addr), first8[it.h - X0]);
            if (it.h == X0 && it.v == Y0 + 1)
                chk("addr_line_y0p1_start", 32'(vram_addr), 0);
            if (it.h == X0 && it.v == Y0 + 2)
                chk("addr_line_y0p2_start", 32'(vram_addr), PIX_W);
            if (it.h == X0 + 2 * PIX_W - 1 && it.v == Y0 + 2 * PIX_H - 1)
                chk("addr_last_pixel", 32'(vram_addr), N_BITS - 1);
            st_de += int'(de);
            st_hs += int'(hsync == HS_POL);
            st_vs += int'(vsync == VS_POL);
            st_fs += int'(frame_start);
        end
    endtask

    task automatic release_reset();
        reset     = 1'b0;
        s_cnt     = 0;
        last_addr = 0;
        pipe.delete();
        exp_out   = RST_OUT;
    endtask

    // gap_mode: idle clocks between strobes (-1 = random 0..2)
    // en_mode : 0 = always on, 1 = mostly on, 2 = off for first half
    task automatic run_frame(input int gap_mode, input int en_mode);
        int gap;
        bit en;
        st_de = 0;
        st_hs = 0;
        st_vs = 0;
        st_fs = 0;
        for (int k = 0; k < F_STROBES; k++) begin
            gap = (gap_mode >= 0) ? gap_mode : int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) tick(1'b0, 1'($urandom));
            case (en_mode)
                0:       en = 1'b1;
                1:       en = ($urandom_range(0, 7) != 0);
                default: en = (k >= F_STROBES / 2);
            endcase
            tick(1'b1, en);
        end
        // any F_STROBES consecutive strobes span exactly one frame
        chk("de_per_frame", st_de, H_ACT * V_ACT);
        chk("hsync_per_frame", st_hs, H_SYNC * V_TOT);
        chk("vsync_per_frame", st_vs, V_SYNC * H_TOT);
        chk("frame_start_per_frame", st_fs, 1);
    endtask

    initial begin
        for (int i = 0; i < N_BITS; i++) mem[i] = 1'($urandom);
        mem[0] = 1'b1;
        mem[1] = 1'b0;

        repeat (3) @(posedge clock);
        #1;
        chk("reset_state", {10'd0, vram_addr, pix, de, hsync, vsync, frame_start},
            {10'd0, 17'd0, RST_OUT});
        release_reset();

        // back-to-back strobes: first frame_start after the third clock
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b1);
        chk("frame_start_clock3", 32'(frame_start), 1);
        run_frame(0, 0);
        run_frame(0, 1);

        // reset asserted part-way through a line, between clock edges
        repeat (500) tick(1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("reset_async", {10'd0, vram_addr, pix, de, hsync, vsync, frame_start},
            {10'd0, 17'd0, RST_OUT});
        pix_ce = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_hold", {10'd0, vram_addr, pix, de, hsync, vsync, frame_start},
            {10'd0, 17'd0, RST_OUT});
        release_reset();

        // all-ones VRAM, strobe every third clock, display disabled then enabled
        for (int i = 0; i < N_BITS; i++) mem[i] = 1'b1;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        run_frame(2, 2);

        // random VRAM contents with irregular strobe spacing
        for (int i = 0; i < N_BITS; i++) mem[i] = 1'($urandom);
        run_frame(-1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
